// File: rtl/cpu_test_pkg.sv
// Package shared by the cpu test sequencer and its readback slot.
// Contents:
//   cts_state_e       sequencer state encoding
//   STOP_OPC_DEFAULT  pseudo-opcode in instr[6:0] that ends a run
//   IMEM/DMEM_BYTE_SHIFT  word index to byte address shifts (32-bit / 64-bit words)
//   TEST_ID_MSB/LSB   position of the test identifier inside the STOP instruction
//   word_to_byte_addr helper turning a word index into a byte address
package cpu_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_D  = 3'd1,
        ST_LOAD_I  = 3'd2,
        ST_RUN     = 3'd3,
        ST_RB_REQ  = 3'd4,
        ST_RB_WAIT = 3'd5,
        ST_DONE    = 3'd6
    } cts_state_e;

    localparam logic [6:0] STOP_OPC_DEFAULT = 7'b1111110;

    localparam int IMEM_BYTE_SHIFT = 2;
    localparam int DMEM_BYTE_SHIFT = 3;

    localparam int TEST_ID_MSB = 31;
    localparam int TEST_ID_LSB = 28;

    function automatic logic [63:0] word_to_byte_addr(input logic [63:0] idx, input int shift);
        return idx << shift;
    endfunction

endpackage

// File: rtl/cts_rb_slot.sv
// One-entry output register with a valid/ready handshake, used to present
// each dmem readback word to the consumer.
// Ports:
//   clk, arst         clock and asynchronous active-high reset
//   load_i            capture data_i/idx_i this cycle (only issued while empty)
//   data_i, idx_i     word and its dmem index to capture
//   valid_o, ready_i  output handshake; entry empties on valid_o && ready_i
//   data_o, idx_o     held stable while valid_o is high
module cts_rb_slot #(
    parameter int DW = 64,
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [IW-1:0] idx_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic [IW-1:0] idx_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [IW-1:0] idx_q;

    // The entry fills on load and empties on the handshake; payload only
    // changes on load, so it stays stable for the whole time valid is held.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            idx_q   <= idx_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/cpu_test_sequencer.sv
// Test sequencer for the cpu core: loads a data image into dmem and a
// program into imem over the external write ports, enables the cpu until the
// STOP pseudo-opcode is fetched (or a cycle limit expires), then streams a
// window of dmem back out through a valid/ready port.
// Ports:
//   clk, arst                      clock, asynchronous active-high reset
//   start                          begin a sequence (ignored while busy)
//   imem_len, dmem_len, rb_base,   sequence setup, sampled on an accepted start
//   rb_len, timeout_cyc
//   ld_valid/ld_ready, ld_data     load word stream (imem uses [31:0])
//   cpu_enable                     cpu run enable
//   addr_ext..wdata_ext            imem external port
//   addr_ext_2..wdata_ext_2        dmem external port, rdata_ext_2 one cycle after ren
//   instr                          fetched instruction monitor
//   rb_valid/rb_ready, rb_data,    readback word stream with its dmem index
//   rb_idx
//   busy, done, timeout, test_id,  status
//   cycle_count
module cpu_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int         IMEM_AW  = 9,
    parameter int         DMEM_AW  = 10,
    parameter int         CNT_W    = 32,
    parameter logic [6:0] STOP_OPC = STOP_OPC_DEFAULT
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               start,
    input  logic [IMEM_AW:0]   imem_len,
    input  logic [DMEM_AW:0]   dmem_len,
    input  logic [DMEM_AW-1:0] rb_base,
    input  logic [DMEM_AW:0]   rb_len,
    input  logic [CNT_W-1:0]   timeout_cyc,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [63:0]        ld_data,
    output logic               cpu_enable,
    output logic [63:0]        addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [31:0]        wdata_ext,
    output logic [63:0]        addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [63:0]        wdata_ext_2,
    input  logic [63:0]        rdata_ext_2,
    input  logic [31:0]        instr,
    output logic               rb_valid,
    input  logic               rb_ready,
    output logic [63:0]        rb_data,
    output logic [DMEM_AW-1:0] rb_idx,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [3:0]         test_id,
    output logic [CNT_W-1:0]   cycle_count
);

    // One counter serves both load phases, so it is as wide as the larger length.
    localparam int LDC_W = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

    cts_state_e         state_q, state_d;

    logic [IMEM_AW:0]   imem_len_q, imem_len_d;
    logic [DMEM_AW:0]   dmem_len_q, dmem_len_d;
    logic [DMEM_AW-1:0] rb_base_q, rb_base_d;
    logic [DMEM_AW:0]   rb_len_q, rb_len_d;
    logic [CNT_W-1:0]   timeout_cyc_q, timeout_cyc_d;

    logic [LDC_W-1:0]   ld_cnt_q, ld_cnt_d;

    logic               wen_q, wen_d;
    logic [63:0]        waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wen2_q, wen2_d;
    logic [63:0]        waddr2_q, waddr2_d;
    logic [63:0]        wdata2_q, wdata2_d;

    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               timeout_q, timeout_d;
    logic [3:0]         test_id_q, test_id_d;

    logic [DMEM_AW-1:0] rb_ptr_q, rb_ptr_d;
    logic [DMEM_AW:0]   rb_cnt_q, rb_cnt_d;
    logic               rd_pend_q, rd_pend_d;

    logic               slot_load;
    logic               stop_seen;
    logic               unused_instr;

    assign stop_seen    = (instr[6:0] == STOP_OPC);
    assign unused_instr = ^instr[TEST_ID_LSB-1:7];

    // Next-state and datapath decisions. Write-port registers default to
    // all-zero so the ext ports are quiet in every cycle that is not a write.
    always_comb begin
        state_d       = state_q;
        imem_len_d    = imem_len_q;
        dmem_len_d    = dmem_len_q;
        rb_base_d     = rb_base_q;
        rb_len_d      = rb_len_q;
        timeout_cyc_d = timeout_cyc_q;
        ld_cnt_d      = ld_cnt_q;
        wen_d         = 1'b0;
        waddr_d       = '0;
        wdata_d       = '0;
        wen2_d        = 1'b0;
        waddr2_d      = '0;
        wdata2_d      = '0;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        test_id_d     = test_id_q;
        rb_ptr_d      = rb_ptr_q;
        rb_cnt_d      = rb_cnt_q;
        rd_pend_d     = 1'b0;
        ld_ready      = 1'b0;
        slot_load     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    imem_len_d    = imem_len;
                    dmem_len_d    = dmem_len;
                    rb_base_d     = rb_base;
                    rb_len_d      = rb_len;
                    timeout_cyc_d = timeout_cyc;
                    timeout_d     = 1'b0;
                    test_id_d     = '0;
                    ld_cnt_d      = '0;
                    if (dmem_len != '0) begin
                        state_d = ST_LOAD_D;
                    end else if (imem_len != '0) begin
                        state_d = ST_LOAD_I;
                    end else begin
                        state_d       = ST_RUN;
                        cycle_count_d = '0;
                    end
                end
            end

            // A finished dmem phase hands straight over to imem (separate
            // port, so no gap). It only lingers one extra cycle when the run
            // follows, so the last write lands before the cpu is enabled.
            ST_LOAD_D: begin
                if (ld_cnt_q != LDC_W'(dmem_len_q)) begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
                        wen2_d   = 1'b1;
                        waddr2_d = word_to_byte_addr(64'(ld_cnt_q[DMEM_AW-1:0]), DMEM_BYTE_SHIFT);
                        wdata2_d = ld_data;
                        if ((ld_cnt_q + LDC_W'(1) == LDC_W'(dmem_len_q)) && (imem_len_q != '0)) begin
                            state_d  = ST_LOAD_I;
                            ld_cnt_d = '0;
                        end else begin
                            ld_cnt_d = ld_cnt_q + LDC_W'(1);
                        end
                    end
                end else begin
                    state_d       = ST_RUN;
                    cycle_count_d = '0;
                end
            end

            ST_LOAD_I: begin
                if (ld_cnt_q != LDC_W'(imem_len_q)) begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
                        wen_d    = 1'b1;
                        waddr_d  = word_to_byte_addr(64'(ld_cnt_q[IMEM_AW-1:0]), IMEM_BYTE_SHIFT);
                        wdata_d  = ld_data[31:0];
                        ld_cnt_d = ld_cnt_q + LDC_W'(1);
                    end
                end else begin
                    state_d       = ST_RUN;
                    cycle_count_d = '0;
                end
            end

            // cycle_count ends as the number of cycles run before STOP was
            // fetched; on a limit it includes the final cycle. STOP is
            // checked first so it wins over a coinciding limit.
            ST_RUN: begin
                if (stop_seen) begin
                    test_id_d = instr[TEST_ID_MSB:TEST_ID_LSB];
                    rb_ptr_d  = rb_base_q;
                    rb_cnt_d  = '0;
                    state_d   = (rb_len_q != '0) ? ST_RB_REQ : ST_DONE;
                end else begin
                    if (cycle_count_q != '1) begin
                        cycle_count_d = cycle_count_q + CNT_W'(1);
                    end
                    if ((timeout_cyc_q != '0) && (cycle_count_q == timeout_cyc_q - CNT_W'(1))) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_RB_REQ: begin
                rd_pend_d = 1'b1;
                state_d   = ST_RB_WAIT;
            end

            // rd_pend_q marks the cycle in which rdata_ext_2 answers the request.
            ST_RB_WAIT: begin
                slot_load = rd_pend_q;
                if (rb_valid && rb_ready) begin
                    rb_cnt_d = rb_cnt_q + (DMEM_AW+1)'(1);
                    rb_ptr_d = rb_ptr_q + DMEM_AW'(1);
                    state_d  = (rb_cnt_q + (DMEM_AW+1)'(1) == rb_len_q) ? ST_DONE : ST_RB_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sequencer state, reset asynchronously so an abort drops the cpu
    // enable and memory strobes at once.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= ST_IDLE;
            imem_len_q    <= '0;
            dmem_len_q    <= '0;
            rb_base_q     <= '0;
            rb_len_q      <= '0;
            timeout_cyc_q <= '0;
            ld_cnt_q      <= '0;
            wen_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            wen2_q        <= 1'b0;
            waddr2_q      <= '0;
            wdata2_q      <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            test_id_q     <= '0;
            rb_ptr_q      <= '0;
            rb_cnt_q      <= '0;
            rd_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_len_q    <= imem_len_d;
            dmem_len_q    <= dmem_len_d;
            rb_base_q     <= rb_base_d;
            rb_len_q      <= rb_len_d;
            timeout_cyc_q <= timeout_cyc_d;
            ld_cnt_q      <= ld_cnt_d;
            wen_q         <= wen_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            wen2_q        <= wen2_d;
            waddr2_q      <= waddr2_d;
            wdata2_q      <= wdata2_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            test_id_q     <= test_id_d;
            rb_ptr_q      <= rb_ptr_d;
            rb_cnt_q      <= rb_cnt_d;
            rd_pend_q     <= rd_pend_d;
        end
    end

    cts_rb_slot #(
        .DW (64),
        .IW (DMEM_AW)
    ) u_rb_slot (
        .clk     (clk),
        .arst    (arst),
        .load_i  (slot_load),
        .data_i  (rdata_ext_2),
        .idx_i   (rb_ptr_q),
        .valid_o (rb_valid),
        .ready_i (rb_ready),
        .data_o  (rb_data),
        .idx_o   (rb_idx)
    );

    assign cpu_enable  = (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign timeout     = timeout_q;
    assign test_id     = test_id_q;
    assign cycle_count = cycle_count_q;

    assign addr_ext    = waddr_q;
    assign wen_ext     = wen_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_q;

    // The dmem port is shared: readback requests drive the address directly
    // from the pointer, writes come from the registered load path.
    assign ren_ext_2   = (state_q == ST_RB_REQ);
    assign addr_ext_2  = ren_ext_2 ? word_to_byte_addr(64'(rb_ptr_q), DMEM_BYTE_SHIFT) : waddr2_q;
    assign wen_ext_2   = wen2_q;
    assign wdata_ext_2 = wdata2_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer: load ordering, STOP detection,
// readback with back-pressure and index wrap, cycle limit, abort by reset
// and start-while-busy.
module tb_cpu_test_sequencer;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic [9:0]  imem_len;
    logic [10:0] dmem_len;
    logic [9:0]  rb_base;
    logic [10:0] rb_len;
    logic [31:0] timeout_cyc;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_data;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = '0;
    logic [31:0] instr;
    logic        rb_valid;
    logic        rb_ready;
    logic [63:0] rb_data;
    logic [9:0]  rb_idx;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [3:0]  test_id;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI = 32'h0010_0093;

    cpu_test_sequencer dut (
        .clk         (clk),
        .arst        (arst),
        .start       (start),
        .imem_len    (imem_len),
        .dmem_len    (dmem_len),
        .rb_base     (rb_base),
        .rb_len      (rb_len),
        .timeout_cyc (timeout_cyc),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .instr       (instr),
        .rb_valid    (rb_valid),
        .rb_ready    (rb_ready),
        .rb_data     (rb_data),
        .rb_idx      (rb_idx),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .test_id     (test_id),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Preloaded dmem image: every word is a function of its index.
    function automatic logic [63:0] dpat(input int idx);
        return {16'hDA7A, 16'(idx), 32'(idx) * 32'h9E37_79B9};
    endfunction

    function automatic logic [31:0] progWord(input int idx);
        return ADDI | (32'(idx) << 20);
    endfunction

    // dmem read port model: data one cycle after ren.
    always @(posedge clk) begin
        if (ren_ext_2) begin
            rdata_ext_2 <= dpat(int'(addr_ext_2[12:3]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int imemN, input int dmemN, input int base, input int rbN,
                                 input int limit);
        imem_len    = 10'(imemN);
        dmem_len    = 11'(dmemN);
        rb_base     = 10'(base);
        rb_len      = 11'(rbN);
        timeout_cyc = 32'(limit);
        start       = 1'b1;
        tick;
        start       = 1'b0;
    endtask

    // Drains a readback with random back-pressure, checking every request
    // address and every accepted beat against the expected index sequence.
    task automatic runReadback(input int base, input int len);
        int n;
        logic seenDone;
        n = 0;
        seenDone = 1'b0;
        for (int k = 0; k < 400 && !seenDone; k++) begin
            if (ren_ext_2) begin
                checkOutput("rb_req_addr", addr_ext_2, 64'(((base + n) % 1024) * 8));
            end
            rb_ready = 1'($urandom_range(0, 1));
            if (rb_valid && rb_ready) begin
                checkOutput("rb_idx", 64'(rb_idx), 64'((base + n) % 1024));
                checkOutput("rb_data", rb_data, dpat((base + n) % 1024));
                n++;
            end
            tick;
            seenDone = done;
        end
        rb_ready = 1'b0;
        checkOutput("rb_beats", 64'(n), 64'(len));
        checkOutput("rb_done", 64'(done), 64'(1));
        checkOutput("rb_valid_after", 64'(rb_valid), 64'(0));
    endtask

    initial begin
        logic rbSeen;

        arst = 1'b1; start = 1'b0; imem_len = '0; dmem_len = '0; rb_base = '0; rb_len = '0;
        timeout_cyc = '0; ld_valid = 1'b0; ld_data = '0; instr = ADDI; rb_ready = 1'b0;
        tick; tick;
        arst = 1'b0;
        tick;

        // Reset state
        checkOutput("rst_cpu_enable", 64'(cpu_enable), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_ld_ready", 64'(ld_ready), 64'(0));
        checkOutput("rst_wen", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'(0));
        checkOutput("rst_rb_valid", 64'(rb_valid), 64'(0));
        checkOutput("rst_status", 64'({timeout, test_id, cycle_count}), 64'(0));

        // Load: 2 dmem words then 4 imem words, ld_valid held high
        $display("[TB] load ordering");
        ld_valid = 1'b1;
        applyStimulus(4, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            ld_data = (i < 2) ? dpat(i) : {32'h0, progWord(i - 2)};
            checkOutput("ld_ready_on", 64'(ld_ready), 64'(1));
            tick;
            if (i < 2) begin
                checkOutput("d_wen", 64'({wen_ext_2, wen_ext}), 64'(2));
                checkOutput("d_addr", addr_ext_2, 64'(i * 8));
                checkOutput("d_wdata", wdata_ext_2, dpat(i));
            end else begin
                checkOutput("i_wen", 64'({wen_ext_2, wen_ext}), 64'(1));
                checkOutput("i_addr", addr_ext, 64'((i - 2) * 4));
                checkOutput("i_wdata", 64'(wdata_ext), 64'(progWord(i - 2)));
            end
        end
        ld_valid = 1'b0;
        checkOutput("ld_ready_off", 64'(ld_ready), 64'(0));
        checkOutput("no_enable_during_write", 64'(cpu_enable), 64'(0));
        tick;

        // Run: 20 ADDI cycles then STOP carrying test id 4
        $display("[TB] run to STOP");
        checkOutput("run_enable", 64'(cpu_enable), 64'(1));
        checkOutput("run_wen_quiet", 64'({wen_ext, wen_ext_2}), 64'(0));
        checkOutput("run_count0", 64'(cycle_count), 64'(0));
        for (int c = 0; c < 20; c++) begin
            tick;
            if (c == 9) checkOutput("run_count10", 64'(cycle_count), 64'(10));
        end
        instr = 32'h4000_007E;
        checkOutput("run_enable_at_stop", 64'(cpu_enable), 64'(1));
        tick;
        instr = ADDI;
        checkOutput("stop_enable_off", 64'(cpu_enable), 64'(0));
        checkOutput("stop_test_id", 64'(test_id), 64'(4));
        checkOutput("stop_count", 64'(cycle_count), 64'(20));
        checkOutput("stop_done_busy", 64'({done, busy, timeout}), 64'(3'b100));

        // Readback window 35..46 with lengths 0 skipping the loads
        $display("[TB] readback 35..46");
        instr = 32'hA000_007E;
        applyStimulus(0, 0, 35, 12, 0);
        checkOutput("skip_load_enable", 64'(cpu_enable), 64'(1));
        checkOutput("restart_clears", 64'({done, timeout, test_id}), 64'(0));
        tick;
        instr = ADDI;
        checkOutput("rb_test_id", 64'(test_id), 64'(10));
        checkOutput("rb_busy", 64'(busy), 64'(1));
        runReadback(35, 12);

        // Cycle limit of 100 with no STOP, plus a start while busy
        $display("[TB] timeout");
        applyStimulus(0, 0, 0, 12, 100);
        rbSeen = 1'b0;
        for (int c = 1; c <= 99; c++) begin
            start = (c == 50);
            if (c == 50) timeout_cyc = 32'd60;
            tick;
            start = 1'b0;
            rbSeen = rbSeen | rb_valid;
            if (c == 50) checkOutput("busy_start_ignored", 64'(cycle_count), 64'(50));
        end
        checkOutput("to_not_yet", 64'({timeout, busy}), 64'(2'b01));
        tick;
        checkOutput("to_flag", 64'({timeout, done, busy}), 64'(3'b110));
        checkOutput("to_count", 64'(cycle_count), 64'(100));
        for (int c = 0; c < 5; c++) begin
            tick;
            rbSeen = rbSeen | rb_valid;
        end
        checkOutput("to_no_readback", 64'(rbSeen), 64'(0));
        checkOutput("to_test_id", 64'(test_id), 64'(0));
        timeout_cyc = '0;

        // Asynchronous abort during LOAD_I
        $display("[TB] reset mid-load");
        ld_valid = 1'b1;
        ld_data  = 64'h1234_5678;
        applyStimulus(8, 1, 0, 0, 0);
        tick;
        tick;
        checkOutput("pre_rst_wen", 64'({wen_ext, ld_ready}), 64'(2'b11));
        #1 arst = 1'b1;
        #1;
        checkOutput("arst_load_wen", 64'({wen_ext, wen_ext_2, ld_ready}), 64'(0));
        checkOutput("arst_load_addr", addr_ext, 64'(0));
        checkOutput("arst_load_state", 64'({busy, done, cpu_enable}), 64'(0));
        ld_valid = 1'b0;
        tick;
        arst = 1'b0;

        // Asynchronous abort while a readback beat is waiting
        $display("[TB] reset mid-readback");
        instr = 32'h3000_007E;
        applyStimulus(0, 0, 5, 3, 0);
        tick;
        tick;
        tick;
        checkOutput("pre_rst_rb_valid", 64'(rb_valid), 64'(1));
        checkOutput("pre_rst_rb_idx", 64'(rb_idx), 64'(5));
        #1 arst = 1'b1;
        #1;
        checkOutput("arst_rb_out", 64'({rb_valid, rb_idx, ren_ext_2}), 64'(0));
        checkOutput("arst_rb_data", rb_data, 64'(0));
        checkOutput("arst_rb_status", 64'({busy, test_id, cycle_count}), 64'(0));
        tick;
        arst = 1'b0;
        tick;

        // Clean run after reset, readback index wrapping 1023 -> 0
        $display("[TB] readback wrap");
        instr = 32'h6000_007E;
        applyStimulus(0, 0, 1020, 8, 0);
        checkOutput("wrap_enable", 64'(cpu_enable), 64'(1));
        tick;
        instr = ADDI;
        runReadback(1020, 8);
        checkOutput("wrap_status", 64'({test_id, timeout}), 64'({4'd6, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
